// File: rtl/param_datapath_pkg.sv
// Shared definitions for param_datapath, its MUL/DIV engine and its bench.
// Holds the opcode and FSM state encodings, the latched-operation record and
// the opcode legality helper.
package param_datapath_pkg;

  localparam int unsigned OP_W = 4;

  // Operation codes; any code above OP_DIV is illegal.
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_MUL = 4'd6,
    OP_DIV = 4'd7
  } op_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operation record captured when a start is accepted.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            wb_en;
  } op_ctrl_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply / restoring divide engine, one step per clock.
// Ports:
//   i_clock, i_clear      : clock, asynchronous active-high clear
//   i_start               : load operands and begin WIDTH iterations
//   i_is_div              : 1 = divide (i_a / i_b), 0 = multiply (i_a * i_b)
//   i_a, i_b              : operands, sampled on the i_start edge
//   o_done_c              : high during the cycle whose closing edge runs the last step
//   o_lo_c, o_hi_c        : result after the step taken at the next edge
//                           (MUL: product low/high, DIV: quotient/remainder)
module seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_lo_c,
  output logic [WIDTH-1:0] o_hi_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_is_div;
  logic             r_run;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;
  logic             w_last;

  // One iteration. MUL: {hi,lo} holds partial product with the multiplier
  // shifting out of lo. DIV: hi is the partial remainder, lo shifts the
  // dividend out and the quotient in.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_b};
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_is_div) begin
      // Top bit of the trial difference set means the divisor did not fit.
      if (!w_trial[WIDTH]) begin
        w_hi_nx = w_trial[WIDTH-1:0];
        w_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nx = w_shift[WIDTH-1:0];
        w_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_nx = w_sum[WIDTH:1];
      w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_last   = r_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_done_c = w_last;
  assign o_lo_c   = w_lo_nx;
  assign o_hi_c   = w_hi_nx;

  // Operand load and iteration counter.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_run    <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_hi     <= '0;
      r_lo     <= i_a;
      r_b      <= i_b;
      r_is_div <= i_is_div;
      r_run    <= 1'b1;
      r_cnt    <= '0;
    end else if (r_run) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_datapath.sv
// Register file plus a small ALU with an iterative MUL/DIV engine.
// Ports:
//   clock, clear                 : clock, asynchronous active-high reset
//   load_en/load_sel/load_data   : external register write
//   start, op_select             : operation request (accepted only in IDLE)
//   src_a, src_b, dst, wb_en     : operand indices, writeback target/enable
//   read_sel, read_data          : combinational register read port
//   busy, done, illegal          : status (done is a one-cycle pulse)
//   z_lo, z_hi                   : registered result halves
module param_datapath
  import param_datapath_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_sel,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     start,
  input  logic [3:0]               op_select,
  input  logic [$clog2(DEPTH)-1:0] src_a,
  input  logic [$clog2(DEPTH)-1:0] src_b,
  input  logic [$clog2(DEPTH)-1:0] dst,
  input  logic                     wb_en,
  input  logic [$clog2(DEPTH)-1:0] read_sel,
  output logic [WIDTH-1:0]         read_data,
  output logic                     busy,
  output logic                     done,
  output logic                     illegal,
  output logic [WIDTH-1:0]         z_lo,
  output logic [WIDTH-1:0]         z_hi
);

  localparam int unsigned SEL_W = $clog2(DEPTH);
  localparam int unsigned SHW   = $clog2(WIDTH);

  logic [WIDTH-1:0] r_regs [DEPTH];
  state_e           r_state;
  op_ctrl_t         r_ctrl;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SEL_W-1:0] r_dst;
  logic [WIDTH-1:0] r_z_lo;
  logic [WIDTH-1:0] r_z_hi;
  logic             r_busy;
  logic             r_done;
  logic             r_illegal;

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic             w_accept;
  logic             w_iter;
  logic             w_load_ok;
  logic             w_wb_ok;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_exec_lo;
  logic [WIDTH-1:0] w_exec_hi;
  logic             w_md_done_c;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;

  // Register 0 is never written when ZERO_REG is set, so plain reads suffice.
  assign read_data = r_regs[read_sel];
  assign w_opa     = r_regs[src_a];
  assign w_opb     = r_regs[src_b];

  assign w_accept  = (r_state == ST_IDLE) && start;
  // Divide by zero takes the single-cycle path.
  assign w_iter    = (op_select == OP_MUL) ||
                     ((op_select == OP_DIV) && (w_opb != '0));
  assign w_load_ok = load_en && ((ZERO_REG == 0) || (load_sel != '0));
  assign w_wb_ok   = r_ctrl.wb_en && ((ZERO_REG == 0) || (r_dst != '0));

  // Single-cycle results from the snapshotted operands.
  always_comb begin
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_diff    = {1'b0, r_a} - {1'b0, r_b};
    w_exec_lo = '0;
    w_exec_hi = '0;
    case (r_ctrl.op)
      OP_ADD: begin
        w_exec_lo = w_sum[WIDTH-1:0];
        w_exec_hi = WIDTH'(w_sum[WIDTH]);
      end
      OP_SUB: begin
        w_exec_lo = w_diff[WIDTH-1:0];
        w_exec_hi = WIDTH'(w_diff[WIDTH]);
      end
      OP_AND: w_exec_lo = r_a & r_b;
      OP_OR:  w_exec_lo = r_a | r_b;
      OP_SHL: w_exec_lo = r_a << r_b[SHW-1:0];
      OP_SHR: w_exec_lo = r_a >> r_b[SHW-1:0];
      OP_DIV: begin
        w_exec_lo = '1;
        w_exec_hi = r_a;
      end
      default: begin
        w_exec_lo = '0;
        w_exec_hi = '0;
      end
    endcase
  end

  seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .i_clock  (clock),
    .i_clear  (clear),
    .i_start  (w_accept && w_iter),
    .i_is_div (op_select == OP_DIV),
    .i_a      (w_opa),
    .i_b      (w_opb),
    .o_done_c (w_md_done_c),
    .o_lo_c   (w_md_lo),
    .o_hi_c   (w_md_hi)
  );

  // Controller, register file and result registers. Writeback is placed
  // after the load so it wins when both target the same register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_dst     <= '0;
      r_z_lo    <= '0;
      r_z_hi    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[SEL_W'(i)] <= '0;
      end
    end else begin
      if (w_load_ok) begin
        r_regs[load_sel] <= load_data;
      end
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_ctrl.op    <= op_select;
            r_ctrl.wb_en <= wb_en;
            r_a          <= w_opa;
            r_b          <= w_opb;
            r_dst        <= dst;
            r_illegal    <= !is_legal_op(op_select);
            r_busy       <= 1'b1;
            r_state      <= w_iter ? ST_ITER : ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_z_lo  <= w_exec_lo;
          r_z_hi  <= w_exec_hi;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
          if (w_wb_ok) begin
            r_regs[r_dst] <= w_exec_lo;
          end
        end
        ST_ITER: begin
          if (w_md_done_c) begin
            r_z_lo  <= w_md_lo;
            r_z_hi  <= w_md_hi;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
            if (w_wb_ok) begin
              r_regs[r_dst] <= w_md_lo;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign illegal = r_illegal;
  assign z_lo    = r_z_lo;
  assign z_hi    = r_z_hi;

endmodule
